// File: rtl/asic_iopoc_seq.sv
// Padring power-on-control sequencer: holds every segment's poc line safe until the
// supplies are good and debounced, then releases the segments one by one with a stagger.
module asic_iopoc_seq #(
  parameter int NSEG     = 4,
  parameter int DEBOUNCE = 8,
  parameter int STAGGER  = 4,
  parameter int CW       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [NSEG-1:0] vddio_ok,
  input  logic            vdd_ok,
  input  logic            clr_fault,
  output logic [NSEG-1:0] poc,
  output logic            ready,
  output logic            fault,
  output logic [2:0]      state
);

  localparam int IW = (NSEG > 1) ? $clog2(NSEG) : 1;

  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_DEBOUNCE = 3'd1;
  localparam logic [2:0] S_RELEASE  = 3'd2;
  localparam logic [2:0] S_ACTIVE   = 3'd3;
  localparam logic [2:0] S_FAULT    = 3'd4;

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] STG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NSEG - 1);

  logic [NSEG-1:0] r_vddio_s1, r_vddio_s2;
  logic            r_vdd_s1, r_vdd_s2;
  logic            w_sok;

  logic [2:0]      r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [IW-1:0]   r_idx, w_idx_next;
  logic [NSEG-1:0] r_poc, w_poc_next;
  logic            r_ready, w_ready_next;
  logic            r_fault, w_fault_next;

  assign w_sok = (&r_vddio_s2) & r_vdd_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vddio_s1 <= '0;
      r_vddio_s2 <= '0;
      r_vdd_s1   <= 1'b0;
      r_vdd_s2   <= 1'b0;
      r_state    <= S_OFF;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_poc      <= '1;
      r_ready    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_vddio_s1 <= vddio_ok;
      r_vddio_s2 <= r_vddio_s1;
      r_vdd_s1   <= vdd_ok;
      r_vdd_s2   <= r_vdd_s1;
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_idx      <= w_idx_next;
      r_poc      <= w_poc_next;
      r_ready    <= w_ready_next;
      r_fault    <= w_fault_next;
    end
  end

  // Supply loss outranks an enable drop once segments may be live.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_OFF:      if (en && w_sok) w_state_next = S_DEBOUNCE;
      S_DEBOUNCE: begin
        if (!w_sok || !en)          w_state_next = S_OFF;
        else if (r_cnt == DEB_LAST) w_state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (!w_sok)                                       w_state_next = S_FAULT;
        else if (!en)                                     w_state_next = S_OFF;
        else if (r_cnt == STG_LAST && r_idx == IDX_LAST)  w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!w_sok)   w_state_next = S_FAULT;
        else if (!en) w_state_next = S_OFF;
      end
      S_FAULT:    if (clr_fault) w_state_next = S_OFF;
      default:    w_state_next = S_OFF;
    endcase
  end

  always_comb begin
    w_cnt_next   = '0;
    w_idx_next   = '0;
    w_poc_next   = '1;
    w_ready_next = 1'b0;
    w_fault_next = r_fault;
    case (w_state_next)
      S_OFF:      w_fault_next = 1'b0;
      S_DEBOUNCE: if (r_state == S_DEBOUNCE) w_cnt_next = r_cnt + 1'b1;
      S_RELEASE: begin
        if (r_state == S_RELEASE) begin
          if (r_cnt == STG_LAST) begin
            w_idx_next = r_idx + 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
            w_idx_next = r_idx;
          end
        end
        // Segments 0..index are released; everything above stays safe.
        for (int k = 0; k < NSEG; k++) w_poc_next[k] = (k > int'(w_idx_next));
      end
      S_ACTIVE: begin
        w_poc_next   = '0;
        w_ready_next = 1'b1;
      end
      S_FAULT:    w_fault_next = 1'b1;
      default:    w_fault_next = r_fault;
    endcase
  end

  assign poc   = r_poc;
  assign ready = r_ready;
  assign fault = r_fault;
  assign state = r_state;

endmodule

// File: tb/tb_asic_iopoc_seq.sv
// Scoreboard bench for asic_iopoc_seq: stimulus queues expected outputs per clock edge,
// a negedge monitor pops and compares them. Covers the 4-segment and 1-segment builds.
module tb_asic_iopoc_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       en0 = 1'b0, vdd0 = 1'b0, clr0 = 1'b0;
  logic [3:0] vddio0 = 4'h0;
  logic [3:0] poc0;
  logic       ready0, fault0;
  logic [2:0] state0;

  logic       en1 = 1'b0, vdd1 = 1'b0, clr1 = 1'b0;
  logic [0:0] vddio1 = 1'b0;
  logic [0:0] poc1;
  logic       ready1, fault1;
  logic [2:0] state1;

  asic_iopoc_seq #(.NSEG(4), .DEBOUNCE(8), .STAGGER(4), .CW(8)) dut0 (
    .clk(clk), .reset(reset), .en(en0), .vddio_ok(vddio0), .vdd_ok(vdd0),
    .clr_fault(clr0), .poc(poc0), .ready(ready0), .fault(fault0), .state(state0)
  );

  asic_iopoc_seq #(.NSEG(1), .DEBOUNCE(1), .STAGGER(1), .CW(8)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .vddio_ok(vddio1), .vdd_ok(vdd1),
    .clr_fault(clr1), .poc(poc1), .ready(ready1), .fault(fault1), .state(state1)
  );

  typedef struct {
    int         cyc;
    int         dut;
    logic [3:0] poc;
    logic       rdy;
    logic       flt;
    logic [2:0] st;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Queue an expectation for the negedge following edge (now + at), kept sorted by cycle.
  task automatic expect_at(input int dut, input int at, input logic [3:0] p, input logic r,
                           input logic f, input logic [2:0] s, input string nm);
    exp_t e;
    int   i;
    e.cyc = edge_cnt + at;
    e.dut = dut;
    e.poc = p;
    e.rdy = r;
    e.flt = f;
    e.st  = s;
    e.nm  = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] ap;
    logic       ar, af;
    logic [2:0] as;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        ap = poc0; ar = ready0; af = fault0; as = state0;
      end else begin
        ap = {3'b000, poc1}; ar = ready1; af = fault1; as = state1;
      end
      checks++;
      if (e.cyc != edge_cnt || ap !== e.poc || ar !== e.rdy || af !== e.flt || as !== e.st) begin
        errors++;
        $display("FAIL %s dut%0d edge %0d: got poc=%b ready=%b fault=%b state=%0d, want poc=%b ready=%b fault=%b state=%0d (due edge %0d)",
                 e.nm, e.dut, edge_cnt, ap, ar, af, as, e.poc, e.rdy, e.flt, e.st, e.cyc);
      end else begin
        $display("ok   %s dut%0d edge %0d: poc=%b ready=%b fault=%b state=%0d",
                 e.nm, e.dut, edge_cnt, ap, ar, af, as);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    expect_at(0, 1, 4'hF, 0, 0, 3'd0, "reset_state");
    expect_at(1, 1, 4'h1, 0, 0, 3'd0, "reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Nominal sequence on both builds
    @(negedge clk);
    expect_at(0, 2,  4'hF, 0, 0, 3'd0, "nom_sync_off");
    expect_at(0, 3,  4'hF, 0, 0, 3'd1, "nom_debounce");
    expect_at(0, 10, 4'hF, 0, 0, 3'd1, "nom_deb_last");
    expect_at(0, 11, 4'hE, 0, 0, 3'd2, "nom_poc0");
    expect_at(0, 14, 4'hE, 0, 0, 3'd2, "nom_hold0");
    expect_at(0, 15, 4'hC, 0, 0, 3'd2, "nom_poc1");
    expect_at(0, 19, 4'h8, 0, 0, 3'd2, "nom_poc2");
    expect_at(0, 23, 4'h0, 0, 0, 3'd2, "nom_poc3");
    expect_at(0, 26, 4'h0, 0, 0, 3'd2, "nom_pre_ready");
    expect_at(0, 27, 4'h0, 1, 0, 3'd3, "nom_ready");
    expect_at(1, 3,  4'h1, 0, 0, 3'd1, "n1_debounce");
    expect_at(1, 4,  4'h0, 0, 0, 3'd2, "n1_poc0");
    expect_at(1, 5,  4'h0, 1, 0, 3'd3, "n1_ready");
    en0 = 1'b1; vddio0 = 4'hF; vdd0 = 1'b1;
    en1 = 1'b1; vddio1 = 1'b1; vdd1 = 1'b1;
    repeat (28) @(negedge clk);

    // Core supply loss while active
    expect_at(0, 2, 4'h0, 1, 0, 3'd3, "flt_pre");
    expect_at(0, 3, 4'hF, 0, 1, 3'd4, "flt_enter");
    expect_at(0, 5, 4'hF, 0, 1, 3'd4, "flt_sticky");
    vdd0 = 1'b0;
    repeat (4) @(negedge clk);
    vdd0 = 1'b1;
    repeat (6) @(negedge clk);

    // Clear the fault and re-run the sequence
    expect_at(0, 1,  4'hF, 0, 0, 3'd0, "clr_off");
    expect_at(0, 2,  4'hF, 0, 0, 3'd1, "clr_debounce");
    expect_at(0, 9,  4'hF, 0, 0, 3'd1, "clr_deb_last");
    expect_at(0, 10, 4'hE, 0, 0, 3'd2, "clr_poc0");
    expect_at(0, 14, 4'hC, 0, 0, 3'd2, "clr_poc1");
    expect_at(0, 15, 4'hC, 0, 0, 3'd2, "clr_hold1");
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    repeat (14) @(negedge clk);

    // Synced supply loss coincides with en drop: fault wins
    expect_at(0, 2, 4'hC, 0, 0, 3'd2, "sim_pre");
    expect_at(0, 3, 4'hF, 0, 1, 3'd4, "sim_fault");
    vddio0 = 4'b1110;
    repeat (2) @(negedge clk);
    en0 = 1'b0;
    repeat (2) @(negedge clk);
    vddio0 = 4'hF;
    repeat (3) @(negedge clk);

    // Clear with en low: stay in OFF
    expect_at(0, 1, 4'hF, 0, 0, 3'd0, "clr2_off");
    expect_at(0, 3, 4'hF, 0, 0, 3'd0, "off_en_low");
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    repeat (2) @(negedge clk);

    // One-cycle glitch on vddio_ok[2] during debounce
    expect_at(0, 1,  4'hF, 0, 0, 3'd1, "gl_debounce");
    expect_at(0, 5,  4'hF, 0, 0, 3'd1, "gl_pre");
    expect_at(0, 6,  4'hF, 0, 0, 3'd0, "gl_off");
    expect_at(0, 7,  4'hF, 0, 0, 3'd1, "gl_restart");
    expect_at(0, 14, 4'hF, 0, 0, 3'd1, "gl_full_deb");
    expect_at(0, 15, 4'hE, 0, 0, 3'd2, "gl_poc0");
    expect_at(0, 17, 4'hE, 0, 0, 3'd2, "gl_hold0");
    en0 = 1'b1;
    repeat (3) @(negedge clk);
    vddio0 = 4'b1011;
    @(negedge clk);
    vddio0 = 4'hF;
    repeat (13) @(negedge clk);

    // en drop alone in RELEASE
    expect_at(0, 1, 4'hF, 0, 0, 3'd0, "en_drop_off");
    en0 = 1'b0;
    @(negedge clk);

    // Run up to poc[1] released, then pulse reset between edges
    expect_at(0, 1,  4'hF, 0, 0, 3'd1, "ar_debounce");
    expect_at(0, 8,  4'hF, 0, 0, 3'd1, "ar_deb_last");
    expect_at(0, 9,  4'hE, 0, 0, 3'd2, "ar_poc0");
    expect_at(0, 13, 4'hC, 0, 0, 3'd2, "ar_poc1");
    expect_at(0, 14, 4'hC, 0, 0, 3'd2, "ar_hold1");
    en0 = 1'b1;
    repeat (14) @(negedge clk);

    expect_at(0, 1,  4'hF, 0, 0, 3'd0, "async_reset");
    expect_at(0, 2,  4'hF, 0, 0, 3'd0, "ar_sync_stage");
    expect_at(0, 3,  4'hF, 0, 0, 3'd1, "ar_restart");
    expect_at(0, 10, 4'hF, 0, 0, 3'd1, "ar_re_deb");
    expect_at(0, 11, 4'hE, 0, 0, 3'd2, "ar_re_poc0");
    expect_at(1, 1,  4'h1, 0, 0, 3'd0, "n1_async_reset");
    expect_at(1, 3,  4'h1, 0, 0, 3'd1, "n1_re_deb");
    expect_at(1, 4,  4'h0, 0, 0, 3'd2, "n1_re_poc0");
    expect_at(1, 5,  4'h0, 1, 0, 3'd3, "n1_re_ready");
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
      errors += sb.size();
      checks += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
